// File: rtl/bus_arb2_if.sv
// rtl/bus_arb2_if.sv - master-side and slave-side bus signals of the two-master arbiter
interface bus_arb2_if;
    logic        m0_rd_req;
    logic        m0_wr_req;
    logic [31:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_ack;

    logic        m1_rd_req;
    logic        m1_wr_req;
    logic [31:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic        s_rd_req;
    logic        s_wr_req;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_rd_ack;
    logic        s_wr_ack;

    // The arbiter masters the shared slave bus and serves both bus masters.
    modport master (
        input  m0_rd_req, m0_wr_req, m0_addr, m0_be, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_rd_req, m1_wr_req, m1_addr, m1_be, m1_wdata,
        output m1_rdata, m1_ack,
        output s_rd_req, s_wr_req, s_addr, s_be, s_wdata,
        input  s_rdata, s_rd_ack, s_wr_ack
    );

    modport slave (
        output m0_rd_req, m0_wr_req, m0_addr, m0_be, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_rd_req, m1_wr_req, m1_addr, m1_be, m1_wdata,
        input  m1_rdata, m1_ack,
        input  s_rd_req, s_wr_req, s_addr, s_be, s_wdata,
        output s_rdata, s_rd_ack, s_wr_ack
    );
endinterface

// File: rtl/bus_arb2.sv
// rtl/bus_arb2.sv - round-robin two-master peripheral bus arbiter with timeout watchdog
module bus_arb2 #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    bus_arb2_if.master  bus,
    output logic        timeout_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic        last_grant_q;
    logic        grant_q;
    logic [15:0] cnt_q;

    logic        req0;
    logic        req1;
    logic        slave_ack;
    logic        grant_en;
    logic        grant_sel;
    logic        grant_wr;
    logic [31:0] grant_addr;
    logic [3:0]  grant_be;
    logic [31:0] grant_wdata;
    logic        complete;
    logic        timed_out;
    logic [31:0] resp_data;

    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        grant_sel   = 1'b0;
        complete    = 1'b0;
        timed_out   = 1'b0;
        req0        = bus.m0_rd_req | bus.m0_wr_req;
        req1        = bus.m1_rd_req | bus.m1_wr_req;
        slave_ack   = bus.s_rd_ack | bus.s_wr_ack;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_en  = 1'b1;
                    // On a tie the master that did not win last time goes next.
                    grant_sel = (req0 && req1) ? ~last_grant_q : req1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (slave_ack) begin
                    complete = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (slave_ack) begin
                    complete = 1'b1;
                    state_d  = S_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        grant_wr    = grant_sel ? bus.m1_wr_req : bus.m0_wr_req;
        grant_addr  = grant_sel ? bus.m1_addr   : bus.m0_addr;
        grant_be    = grant_sel ? bus.m1_be     : bus.m0_be;
        grant_wdata = grant_sel ? bus.m1_wdata  : bus.m0_wdata;
        resp_data   = timed_out ? TIMEOUT_DATA  : bus.s_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            bus.s_rd_req <= 1'b0;
            bus.s_wr_req <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_be     <= '0;
            bus.s_wdata  <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
            timeout_err  <= 1'b0;
            err_addr     <= '0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            bus.s_rd_req <= 1'b0;
            bus.s_wr_req <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            timeout_err  <= 1'b0;

            if (grant_en) begin
                grant_q      <= grant_sel;
                last_grant_q <= grant_sel;
                bus.s_addr   <= grant_addr;
                bus.s_be     <= grant_be;
                bus.s_wdata  <= grant_wdata;
                bus.s_wr_req <= grant_wr;
                bus.s_rd_req <= ~grant_wr;
            end

            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Read data register doubles as the per-master hold register.
            if (complete) begin
                if (grant_q) begin
                    bus.m1_ack   <= 1'b1;
                    bus.m1_rdata <= resp_data;
                end else begin
                    bus.m0_ack   <= 1'b1;
                    bus.m0_rdata <= resp_data;
                end
            end

            if (timed_out) begin
                timeout_err <= 1'b1;
                err_addr    <= bus.s_addr;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// tb/tb_bus_arb2.sv - scoreboard bench for the two-master bus arbiter
module tb_bus_arb2;

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        timeout_err;
    logic [31:0] err_addr;
    logic [7:0]  err_count;
    logic        timeout_err2;
    logic [31:0] err_addr2;
    logic [7:0]  err_count2;

    bus_arb2_if bus ();
    bus_arb2_if bus2 ();

    bus_arb2 dut (
        .clk(clk), .reset(reset), .bus(bus),
        .timeout_err(timeout_err), .err_addr(err_addr), .err_count(err_count)
    );

    bus_arb2 #(.TIMEOUT(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .timeout_err(timeout_err2), .err_addr(err_addr2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   grant_log[$];
    bit   strobe_seen;
    int   strobe_cyc;
    int   ack_cyc;
    int   exp_err;
    int   tmo_pulses;

    bit          cmd_wr[2];
    logic [31:0] cmd_addr[2];
    logic [3:0]  cmd_be[2];
    logic [31:0] cmd_wdata[2];
    int          cmd_reps[2];
    int          cmd_tok[2];
    int          slave_delay;
    int          stray_tok;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h0300_0000) ? 32'h0000_0042 : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd, input bit tmo);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = a; e.be = be; e.wdata = wd; e.rdata = rd; e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic issue(input int m, input bit wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int reps);
        cmd_wr[m] = wr; cmd_addr[m] = a; cmd_be[m] = be; cmd_wdata[m] = wd;
        cmd_reps[m] = reps;
        cmd_tok[m]++;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Masters and slave model: one process owns every DUT input of the main bus.
    task automatic driver();
        int          seen_tok[2];
        int          left[2];
        bit          pend;
        bit          pend_wr;
        int          rem;
        logic [31:0] pend_addr;
        int          stray_seen;
        seen_tok = '{0, 0}; left = '{0, 0}; pend = 0; pend_wr = 0; rem = 0;
        pend_addr = '0; stray_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (cmd_tok[m] != seen_tok[m]) begin
                    seen_tok[m] = cmd_tok[m];
                    left[m] = cmd_reps[m];
                end
            end
            if (bus.m0_ack && left[0] > 0) left[0]--;
            if (bus.m1_ack && left[1] > 0) left[1]--;
            bus.s_rd_ack = 1'b0; bus.s_wr_ack = 1'b0; bus.s_rdata = '0;
            if (bus.s_rd_req || bus.s_wr_req) begin
                pend = (slave_delay >= 0); rem = slave_delay;
                pend_wr = bus.s_wr_req; pend_addr = bus.s_addr;
            end
            if (reset) pend = 0;
            if (pend) begin
                if (rem == 0) begin
                    if (pend_wr) bus.s_wr_ack = 1'b1;
                    else begin bus.s_rd_ack = 1'b1; bus.s_rdata = rdata_of(pend_addr); end
                    pend = 0;
                end else rem--;
            end
            if (stray_tok != stray_seen) begin
                stray_seen = stray_tok;
                bus.s_rd_ack = 1'b1; bus.s_rdata = 32'h0BAD_0BAD;
            end
            bus.m0_rd_req = (left[0] > 0) && !cmd_wr[0];
            bus.m0_wr_req = (left[0] > 0) &&  cmd_wr[0];
            bus.m0_addr = cmd_addr[0]; bus.m0_be = cmd_be[0]; bus.m0_wdata = cmd_wdata[0];
            bus.m1_rd_req = (left[1] > 0) && !cmd_wr[1];
            bus.m1_wr_req = (left[1] > 0) &&  cmd_wr[1];
            bus.m1_addr = cmd_addr[1]; bus.m1_be = cmd_be[1]; bus.m1_wdata = cmd_wdata[1];
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   m;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.s_rd_req || bus.s_wr_req) begin
                    strobe_cyc = cyc;
                    chk("strobe_excl", 32'(bus.s_rd_req & bus.s_wr_req), 32'd0);
                    chk("strobe_once", 32'(strobe_seen), 32'd0);
                    strobe_seen = 1;
                    chk("strobe_has_txn", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb[0];
                        chk("s_wr_req", 32'(bus.s_wr_req), 32'(e.wr));
                        chk("s_addr", bus.s_addr, e.addr);
                        chk("s_be", 32'(bus.s_be), 32'(e.be));
                        if (e.wr) chk("s_wdata", bus.s_wdata, e.wdata);
                    end
                end
                if (bus.m0_ack || bus.m1_ack) begin
                    ack_cyc = cyc;
                    chk("ack_excl", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
                    chk("ack_has_txn", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        m = bus.m1_ack ? 1 : 0;
                        grant_log.push_back(m);
                        chk("ack_master", 32'(m), 32'(e.m));
                        chk("ack_after_strobe", 32'(strobe_seen), 32'd1);
                        strobe_seen = 0;
                        if (!e.wr) chk("rdata", m ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                        chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
                        if (e.tmo) begin
                            chk("err_addr", err_addr, e.addr);
                            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
                            tmo_pulses++;
                        end
                        chk("err_count", 32'(err_count), 32'(exp_err));
                    end
                end else begin
                    chk("timeout_err_idle", 32'(timeout_err), 32'd0);
                end
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_s_rd_req"}, 32'(bus.s_rd_req), 32'd0);
        chk({tag, "_s_wr_req"}, 32'(bus.s_wr_req), 32'd0);
        chk({tag, "_s_addr"}, bus.s_addr, 32'd0);
        chk({tag, "_m0_ack"}, 32'(bus.m0_ack), 32'd0);
        chk({tag, "_m1_ack"}, 32'(bus.m1_ack), 32'd0);
        chk({tag, "_m0_rdata"}, bus.m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, bus.m1_rdata, 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete(); strobe_seen = 0; exp_err = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int pulses2;
        reset = 1'b1;
        cmd_wr = '{0, 0}; cmd_addr = '{0, 0}; cmd_be = '{0, 0}; cmd_wdata = '{0, 0};
        cmd_reps = '{0, 0}; cmd_tok = '{0, 0};
        slave_delay = 1; stray_tok = 0; strobe_seen = 0; exp_err = 0; tmo_pulses = 0;
        strobe_cyc = 0; ack_cyc = 0;
        bus.m0_rd_req = 0; bus.m0_wr_req = 0; bus.m0_addr = '0; bus.m0_be = '0; bus.m0_wdata = '0;
        bus.m1_rd_req = 0; bus.m1_wr_req = 0; bus.m1_addr = '0; bus.m1_be = '0; bus.m1_wdata = '0;
        bus.s_rdata = '0; bus.s_rd_ack = 0; bus.s_wr_ack = 0;
        bus2.m0_rd_req = 0; bus2.m0_wr_req = 0; bus2.m0_addr = 32'h0A00_0000; bus2.m0_be = 4'hF;
        bus2.m0_wdata = '0; bus2.m1_rd_req = 0; bus2.m1_wr_req = 0; bus2.m1_addr = '0;
        bus2.m1_be = '0; bus2.m1_wdata = '0; bus2.s_rdata = '0; bus2.s_rd_ack = 0; bus2.s_wr_ack = 0;
        fork
            driver();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_dut2_err_count", 32'(err_count2), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read with minimum latency
        slave_delay = 1;
        push(0, 0, 32'h0300_0000, 4'hF, 32'h0, 32'h0000_0042, 0);
        t0 = cyc;
        issue(0, 0, 32'h0300_0000, 4'hF, 32'h0, 1);
        wait_drain(20);
        chk("lat_strobe", 32'(strobe_cyc), 32'(t0 + 2));
        chk("lat_ack", 32'(ack_cyc), 32'(t0 + 4));
        repeat (3) @(negedge clk);
        chk("m0_rdata_hold", bus.m0_rdata, 32'h0000_0042);

        // Simultaneous writes after reset: master 0 first
        pulse_reset();
        push(0, 1, 32'h0300_0010, 4'h3, 32'h1111_2222, 32'h0, 0);
        push(1, 1, 32'h0300_0020, 4'hC, 32'h3333_4444, 32'h0, 0);
        issue(0, 1, 32'h0300_0010, 4'h3, 32'h1111_2222, 1);
        issue(1, 1, 32'h0300_0020, 4'hC, 32'h3333_4444, 1);
        wait_drain(40);

        // Continuous requests from both masters alternate
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, 0, 32'h0200_0100, 4'hF, 32'h0, rdata_of(32'h0200_0100), 0);
            push(1, 0, 32'h0200_0200, 4'hF, 32'h0, rdata_of(32'h0200_0200), 0);
        end
        issue(0, 0, 32'h0200_0100, 4'hF, 32'h0, 3);
        issue(1, 0, 32'h0200_0200, 4'hF, 32'h0, 3);
        wait_drain(100);
        chk("rr_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

        // Unmapped address: watchdog completes the read
        repeat (2) @(negedge clk);
        slave_delay = -1;
        tmo_pulses = 0;
        push(1, 0, 32'h0F00_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
        t0 = cyc;
        issue(1, 0, 32'h0F00_0000, 4'hF, 32'h0, 1);
        wait_drain(400);
        chk("tmo_lat_ack", 32'(ack_cyc), 32'(t0 + 258));
        chk("tmo_pulses", 32'(tmo_pulses), 32'd1);
        chk("tmo_err_addr", err_addr, 32'h0F00_0000);
        chk("tmo_err_count", 32'(err_count), 32'd1);

        // Ack on the last watchdog cycle wins
        repeat (2) @(negedge clk);
        slave_delay = 255;
        push(0, 0, 32'h0400_0010, 4'hF, 32'h0, rdata_of(32'h0400_0010), 0);
        t0 = cyc;
        issue(0, 0, 32'h0400_0010, 4'hF, 32'h0, 1);
        wait_drain(400);
        chk("tie_lat_ack", 32'(ack_cyc), 32'(t0 + 258));
        chk("tie_err_count", 32'(err_count), 32'd1);

        // One cycle too late: timeout, late ack lands in RESP and is ignored
        repeat (2) @(negedge clk);
        slave_delay = 256;
        push(0, 0, 32'h0400_0020, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
        issue(0, 0, 32'h0400_0020, 4'hF, 32'h0, 1);
        wait_drain(400);
        chk("late_err_count", 32'(err_count), 32'd2);
        repeat (3) @(negedge clk);
        chk("late_no_extra_ack", 32'(bus.m0_ack | bus.m1_ack), 32'd0);

        // Reset while waiting: abandoned, re-request completes
        slave_delay = -1;
        push(0, 0, 32'h0500_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
        issue(0, 0, 32'h0500_0000, 4'hF, 32'h0, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        sb.delete(); strobe_seen = 0; exp_err = 0; slave_delay = 1;
        @(negedge clk);
        chk_zero_outputs("wait_reset");
        push(0, 0, 32'h0500_0000, 4'hF, 32'h0, rdata_of(32'h0500_0000), 0);
        reset = 1'b0;
        wait_drain(40);
        repeat (2) @(negedge clk);
        stray_tok++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stray_no_ack", 32'(bus.m0_ack | bus.m1_ack), 32'd0);
        end

        // Saturation on the short-watchdog instance
        bus2.m0_rd_req = 1'b1;
        pulses2 = 0;
        for (int i = 0; i < 4000 && pulses2 < 300; i++) begin
            @(negedge clk);
            if (timeout_err2) begin
                pulses2++;
                chk("sat_step", 32'(err_count2), 32'(pulses2 > 255 ? 255 : pulses2));
            end
        end
        chk("sat_pulses", 32'(pulses2), 32'd300);
        chk("sat_count", 32'(err_count2), 32'd255);
        chk("sat_rdata", bus2.m0_rdata, 32'hDEAD_BEEF);
        chk("sat_err_addr", err_addr2, 32'h0A00_0000);
        bus2.m0_rd_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
